adsr_poly_core: RTL and testbench
=================================

Name: adsr_poly_core

Overview:
Multi-channel, parametrised ADSR envelope generator on the standard slot bus (cs/read/write/addr/wr_data/rd_data).
- Holds NCH independent envelope engines, each with its own step, level and time registers.
- Adds gate (key-on/key-off) sustain mode, retrigger from the current level, hard abort and per-channel state readback.
- Envelopes feed the DDS/sampler amplitude path as a packed bus.

Parameters:
NCH, 4, number of envelope channels (1..4; addr[4:3] selects the channel)
ENV_W, 16, output envelope width per channel (1..31)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
cs  in  1  slot select
read  in  1  slot read strobe (no side effects)
write  in  1  slot write strobe
addr  in  5  [4:3] channel, [2:0] register
wr_data  in  32  write data
rd_data  out  32  read data (combinational)
adsr_env  out  NCH*ENV_W  packed envelopes; channel k at [k*ENV_W +: ENV_W]
adsr_idle  out  NCH  per-channel idle flags

Behaviour:
- Register map per channel, selected by addr[2:0]:
  - 0: ctrl, write-only strobes. bit0 start, bit1 stop, bit2 abort.
  - 1: atk_step.
  - 2: dcy_step.
  - 3: sus_time (cycles).
  - 4: rel_step.
  - 5: sus_level.
  - 6: mode. bit0 = 1 selects gate mode, 0 selects timed mode.
  - Writes to channel index >= NCH are ignored.
- Readback, decoded from addr[2:0]:
  - 0: {27'b0, state[2:0], 1'b0, idle} for the selected channel.
  - 7: {(32-NCH)'b0, idle vector}.
  - All others read 0.
- Reset (reset_n low, asynchronous):
  - All registers 0, all FSMs IDLE, accumulators 0.
  - adsr_env all 0, adsr_idle all 1.
- Accumulator: 32 bits, value range 0..MAX = 0x7FFF_FFFF. Compare in 33-bit arithmetic so overflow and underflow are detected.
- Output slice: adsr_env channel = acc[30 -: ENV_W], combinational from the acc register.
- FSM states: IDLE=0, ATTACK=1, DECAY=2, SUSTAIN=3, RELEASE=4.
- Ctrl priority within one write: abort > start > stop.
- abort, from any state: next cycle IDLE, acc=0.
- start, from any state:
  - next cycle ATTACK.
  - acc is kept (retrigger from current level, no click).
  - Sustain counter is cleared.
- stop:
  - from ATTACK, DECAY or SUSTAIN: next cycle RELEASE, acc kept.
  - ignored in IDLE and RELEASE.
- Per-cycle update in each state:
  - ATTACK: if acc+atk_step >= MAX or atk_step==0, then acc=MAX and go to DECAY. Otherwise acc += atk_step.
  - DECAY: if acc <= sus_level+dcy_step or dcy_step==0, then acc=sus_level and go to SUSTAIN. Otherwise acc -= dcy_step. The comparison is unsigned 33-bit.
  - SUSTAIN, timed mode: count cycles in SUSTAIN; on count==sus_time go to RELEASE. sus_time=0 gives 1 cycle in SUSTAIN.
  - SUSTAIN, gate mode: hold until stop, start or abort. sus_time is ignored.
  - RELEASE: if acc <= rel_step or rel_step==0, then acc=0 and go to IDLE. Otherwise acc -= rel_step.
- sus_level values above MAX are clamped to MAX.
- Latency: the ctrl write at edge t changes state at t. The first acc update is at edge t+1.
- Parameter writes during operation take effect on the next update.
- Channels are fully independent.
- Writes to different channels in consecutive cycles behave as isolated writes.

Decomposition:
- Package adsr_pkg:
  - state enum adsr_state_t.
  - register address constants (REG_CTRL..REG_MODE, REG_IDLE_VEC=7).
  - ctrl bit indices.
  - ENV_MAX = 32'h7FFF_FFFF.
- Sub-module adsr_chan: one engine (registers, FSM, accumulator, sustain counter), instantiated NCH times via generate.
- The top level holds the address decode, the write-enable fan-out and the read mux.

Test Plan:
1. Channel 0, timed mode.
   - Setup: atk_step=0x0800_0000, dcy_step=0x1000_0000, sus_level=0x4000_0000, sus_time=10, rel_step=0x1000_0000; write start.
   - Attack: 16 ATTACK cycles; env reaches 0xF000 after 15 updates, then 0xFFFF.
   - Decay: 4 DECAY cycles ending at env 0x8000.
   - Sustain: 11 SUSTAIN cycles.
   - Release: 4 RELEASE cycles to env 0; adsr_idle[0]=1.
2. Gate mode on channel 1, same values.
   - Holds SUSTAIN at 0x8000 for 1000 cycles.
   - stop -> RELEASE next cycle, then reaches 0.
   - Channel 0 remains undisturbed throughout.
3. Retrigger: start written during RELEASE at acc=0x2000_0000.
   - ATTACK resumes from 0x2000_0000 with no drop to 0.
   - Reaches MAX after 12 updates.
4. Zero steps: atk_step=0, dcy_step=0.
   - ATTACK lasts 1 cycle with env 0xFFFF.
   - DECAY lasts 1 cycle, then env equals sus_level.
   - rel_step=0 -> immediate IDLE.
5. Simultaneous bits, abort, reset and readback:
   - ctrl=0b111 mid-DECAY -> IDLE, env 0.
   - reset_n pulsed low mid-ATTACK -> all outputs at reset values immediately.
   - Read addr 7 returns the idle vector.
   - Read addr {ch,0} returns state.
6. Channel-select bounds: with NCH=2, writes to addr[4:3]=3 have no effect, and reads of idle vector bits above NCH are 0.

Source files
------------

// File: rtl/adsr_pkg.sv
`default_nettype none
// ---------------------------------------------------------------
// adsr_pkg: shared types and register map for the ADSR core
// Revision 1.0
// ---------------------------------------------------------------
package adsr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_t;

  localparam logic [2:0] REG_CTRL      = 3'd0;
  localparam logic [2:0] REG_ATK_STEP  = 3'd1;
  localparam logic [2:0] REG_DCY_STEP  = 3'd2;
  localparam logic [2:0] REG_SUS_TIME  = 3'd3;
  localparam logic [2:0] REG_REL_STEP  = 3'd4;
  localparam logic [2:0] REG_SUS_LEVEL = 3'd5;
  localparam logic [2:0] REG_MODE      = 3'd6;
  localparam logic [2:0] REG_IDLE_VEC  = 3'd7;

  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_ABORT = 2;

  localparam logic [31:0] ENV_MAX = 32'h7FFF_FFFF;

  function automatic logic [31:0] clamp_level(input logic [31:0] value);
    return (value > ENV_MAX) ? ENV_MAX : value;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adsr_poly_core_if.sv
`default_nettype none
// ---------------------------------------------------------------
// adsr_poly_core_if: slot bus (cs/read/write/addr/wr_data/rd_data)
// Revision 1.0
// ---------------------------------------------------------------
interface adsr_poly_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [4:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface
`default_nettype wire

// File: rtl/adsr_chan.sv
`default_nettype none
// ---------------------------------------------------------------
// adsr_chan: one envelope engine (registers, FSM, accumulator)
// Revision 1.0
// ---------------------------------------------------------------
module adsr_chan
  import adsr_pkg::*;
#(
  parameter int ENV_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             we,
  input  logic [2:0]       reg_addr,
  input  logic [31:0]      wr_data,
  output logic [ENV_W-1:0] env,
  output logic             idle,
  output adsr_state_t      state
);

  logic [31:0] r_atk_step, r_dcy_step, r_sus_time, r_rel_step, r_sus_level;
  logic        r_gate_mode;
  adsr_state_t r_state, w_state_nxt;
  logic [31:0] r_acc, w_acc_nxt;
  logic [31:0] r_sus_cnt, w_sus_cnt_nxt;
  logic        w_ctrl;
  logic [32:0] w_atk_sum, w_dcy_floor;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_atk_step  <= '0;
      r_dcy_step  <= '0;
      r_sus_time  <= '0;
      r_rel_step  <= '0;
      r_sus_level <= '0;
      r_gate_mode <= 1'b0;
    end else if (we) begin
      case (reg_addr)
        REG_ATK_STEP:  r_atk_step  <= wr_data;
        REG_DCY_STEP:  r_dcy_step  <= wr_data;
        REG_SUS_TIME:  r_sus_time  <= wr_data;
        REG_REL_STEP:  r_rel_step  <= wr_data;
        REG_SUS_LEVEL: r_sus_level <= clamp_level(wr_data);
        REG_MODE:      r_gate_mode <= wr_data[0];
        default:       ;
      endcase
    end
  end

  assign w_ctrl      = we && (reg_addr == REG_CTRL);
  // 33-bit sums so a step that would wrap past MAX is still caught
  assign w_atk_sum   = {1'b0, r_acc} + {1'b0, r_atk_step};
  assign w_dcy_floor = {1'b0, r_sus_level} + {1'b0, r_dcy_step};

  always_comb begin
    w_state_nxt   = r_state;
    w_acc_nxt     = r_acc;
    w_sus_cnt_nxt = r_sus_cnt;
    if (w_ctrl && wr_data[CTRL_ABORT]) begin
      w_state_nxt   = ST_IDLE;
      w_acc_nxt     = '0;
      w_sus_cnt_nxt = '0;
    end else if (w_ctrl && wr_data[CTRL_START]) begin
      w_state_nxt   = ST_ATTACK;
      w_sus_cnt_nxt = '0;
    end else if (w_ctrl && wr_data[CTRL_STOP] &&
                 (r_state inside {ST_ATTACK, ST_DECAY, ST_SUSTAIN})) begin
      w_state_nxt = ST_RELEASE;
    end else begin
      case (r_state)
        ST_ATTACK: begin
          if ((r_atk_step == '0) || (w_atk_sum >= {1'b0, ENV_MAX})) begin
            w_acc_nxt   = ENV_MAX;
            w_state_nxt = ST_DECAY;
          end else begin
            w_acc_nxt = w_atk_sum[31:0];
          end
        end
        ST_DECAY: begin
          if ((r_dcy_step == '0) || ({1'b0, r_acc} <= w_dcy_floor)) begin
            w_acc_nxt     = r_sus_level;
            w_state_nxt   = ST_SUSTAIN;
            w_sus_cnt_nxt = '0;
          end else begin
            w_acc_nxt = r_acc - r_dcy_step;
          end
        end
        ST_SUSTAIN: begin
          if (!r_gate_mode) begin
            if (r_sus_cnt == r_sus_time) begin
              w_state_nxt   = ST_RELEASE;
              w_sus_cnt_nxt = '0;
            end else begin
              w_sus_cnt_nxt = r_sus_cnt + 32'd1;
            end
          end
        end
        ST_RELEASE: begin
          if ((r_rel_step == '0) || (r_acc <= r_rel_step)) begin
            w_acc_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_acc_nxt = r_acc - r_rel_step;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_acc     <= '0;
      r_sus_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_acc     <= w_acc_nxt;
      r_sus_cnt <= w_sus_cnt_nxt;
    end
  end

  assign env   = r_acc[30 -: ENV_W];
  assign idle  = (r_state == ST_IDLE);
  assign state = r_state;

endmodule
`default_nettype wire

// File: rtl/adsr_poly_core.sv
`default_nettype none
// ---------------------------------------------------------------
// adsr_poly_core: NCH-channel ADSR generator on the slot bus
// Revision 1.0
// ---------------------------------------------------------------
module adsr_poly_core
  import adsr_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int ENV_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adsr_poly_core_if.slave      bus,
  output logic [NCH*ENV_W-1:0] adsr_env,
  output logic [NCH-1:0]       adsr_idle
);

  logic [1:0]  w_ch;
  logic [2:0]  w_reg;
  logic        w_wr;
  adsr_state_t w_state [NCH];
  adsr_state_t w_state_all [4];
  logic [3:0]  w_idle_all;

  assign w_ch  = bus.addr[4:3];
  assign w_reg = bus.addr[2:0];
  assign w_wr  = bus.cs && bus.write;

  for (genvar k = 0; k < NCH; k++) begin : g_chan
    adsr_chan #(.ENV_W(ENV_W)) u_chan (
      .clk      (clk),
      .reset_n  (reset_n),
      .we       (w_wr && (w_ch == 2'(k))),
      .reg_addr (w_reg),
      .wr_data  (bus.wr_data),
      .env      (adsr_env[k*ENV_W +: ENV_W]),
      .idle     (adsr_idle[k]),
      .state    (w_state[k])
    );
  end

  // Pad to the full 2-bit channel space so readback of absent channels is safe
  always_comb begin
    w_idle_all = '0;
    for (int k = 0; k < 4; k++) w_state_all[k] = ST_IDLE;
    for (int k = 0; k < NCH; k++) begin
      w_idle_all[k]  = adsr_idle[k];
      w_state_all[k] = w_state[k];
    end
  end

  always_comb begin
    bus.rd_data = '0;
    if (bus.cs && bus.read) begin
      case (w_reg)
        REG_CTRL: begin
          if (int'(w_ch) < NCH)
            bus.rd_data = {27'b0, w_state_all[w_ch], 1'b0, w_idle_all[w_ch]};
        end
        REG_IDLE_VEC: bus.rd_data = 32'(adsr_idle);
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adsr_poly_core.sv
`default_nettype none
// ---------------------------------------------------------------
// tb_adsr_poly_core: checks adsr_poly_core against an arithmetic envelope model
// Revision 1.0
// ---------------------------------------------------------------
module tb_adsr_poly_core;
  import adsr_pkg::*;

  localparam longint MAXV = 64'h7FFF_FFFF;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  adsr_poly_core_if bus0 ();
  adsr_poly_core_if bus1 ();

  logic [63:0] env0;
  logic [3:0]  idle0;
  logic [31:0] env1;
  logic [1:0]  idle1;

  adsr_poly_core #(.NCH(4), .ENV_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus0.slave), .adsr_env(env0), .adsr_idle(idle0)
  );
  adsr_poly_core #(.NCH(2), .ENV_W(16)) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus1.slave), .adsr_env(env1), .adsr_idle(idle1)
  );

  // Model: phase 0 idle,1 attack,2 decay,3 sustain,4 release; level as plain integer
  int     m_ph  [4];
  longint m_lvl [4], m_cnt [4];
  longint m_atk [4], m_dcy [4], m_sus [4], m_rel [4], m_tim [4];
  bit     m_gate[4];
  int     n_vec = 0;
  int     n_err = 0;

  function automatic void model_reset();
    for (int c = 0; c < 4; c++) begin
      m_ph[c] = 0; m_lvl[c] = 0; m_cnt[c] = 0; m_atk[c] = 0; m_dcy[c] = 0;
      m_sus[c] = 0; m_rel[c] = 0; m_tim[c] = 0; m_gate[c] = 0;
    end
  endfunction

  function automatic void model_edge(input bit wr, input logic [4:0] a, input logic [31:0] d);
    for (int c = 0; c < 4; c++) begin
      bit hit = wr && (int'(a[4:3]) == c);
      bit ctl = hit && (a[2:0] == 3'd0);
      if (ctl && d[2]) begin
        m_ph[c] = 0; m_lvl[c] = 0;
      end else if (ctl && d[0]) begin
        m_ph[c] = 1; m_cnt[c] = 0;
      end else if (ctl && d[1] && m_ph[c] >= 1 && m_ph[c] <= 3) begin
        m_ph[c] = 4;
      end else begin
        case (m_ph[c])
          1: if (m_atk[c] == 0 || m_lvl[c] + m_atk[c] >= MAXV) begin
               m_lvl[c] = MAXV; m_ph[c] = 2;
             end else m_lvl[c] += m_atk[c];
          2: if (m_dcy[c] == 0 || m_lvl[c] <= m_sus[c] + m_dcy[c]) begin
               m_lvl[c] = m_sus[c]; m_ph[c] = 3; m_cnt[c] = 0;
             end else m_lvl[c] -= m_dcy[c];
          3: if (!m_gate[c]) begin
               if (m_cnt[c] == m_tim[c]) m_ph[c] = 4;
               else m_cnt[c]++;
             end
          4: if (m_rel[c] == 0 || m_lvl[c] <= m_rel[c]) begin
               m_lvl[c] = 0; m_ph[c] = 0;
             end else m_lvl[c] -= m_rel[c];
          default: ;
        endcase
      end
      if (hit) begin
        case (a[2:0])
          3'd1: m_atk[c] = longint'(d);
          3'd2: m_dcy[c] = longint'(d);
          3'd3: m_tim[c] = longint'(d);
          3'd4: m_rel[c] = longint'(d);
          3'd5: m_sus[c] = (longint'(d) > MAXV) ? MAXV : longint'(d);
          3'd6: m_gate[c] = d[0];
          default: ;
        endcase
      end
    end
  endfunction

  function automatic logic [15:0] model_env(input int c);
    return 16'(m_lvl[c] >> 15);
  endfunction

  function automatic logic [31:0] model_rd(input logic [4:0] a);
    int c = int'(a[4:3]);
    if (a[2:0] == 3'd0) return {27'b0, 3'(m_ph[c]), 1'b0, 1'(m_ph[c] == 0)};
    if (a[2:0] == 3'd7) return {28'b0, 1'(m_ph[3] == 0), 1'(m_ph[2] == 0),
                                1'(m_ph[1] == 0), 1'(m_ph[0] == 0)};
    return 32'h0;
  endfunction

  function automatic logic [15:0] env_of(input int c);
    return env0[c*16 +: 16];
  endfunction

  task automatic step(input bit wr, input logic [4:0] a, input logic [31:0] d);
    bus0.cs = wr; bus0.write = wr; bus0.read = 1'b0; bus0.addr = a; bus0.wr_data = d;
    @(posedge clk);
    model_edge(wr, a, d);
    #1;
    bus0.cs = 1'b0; bus0.write = 1'b0;
  endtask

  task automatic rd0(input logic [4:0] a, output logic [31:0] v);
    bus0.cs = 1'b1; bus0.read = 1'b1; bus0.write = 1'b0; bus0.addr = a;
    #1;
    v = bus0.rd_data;
    bus0.cs = 1'b0; bus0.read = 1'b0;
  endtask

  task automatic step1(input logic [4:0] a, input logic [31:0] d);
    bus1.cs = 1'b1; bus1.write = 1'b1; bus1.read = 1'b0; bus1.addr = a; bus1.wr_data = d;
    @(posedge clk);
    #1;
    bus1.cs = 1'b0; bus1.write = 1'b0;
  endtask

  task automatic rd1(input logic [4:0] a, output logic [31:0] v);
    bus1.cs = 1'b1; bus1.read = 1'b1; bus1.write = 1'b0; bus1.addr = a;
    #1;
    v = bus1.rd_data;
    bus1.cs = 1'b0; bus1.read = 1'b0;
  endtask

  task automatic prog(input int ch, input logic [31:0] atk, dcy, sus, tim, rel, input logic md);
    logic [1:0] c = 2'(ch);
    step(1, {c, REG_ATK_STEP}, atk);
    step(1, {c, REG_DCY_STEP}, dcy);
    step(1, {c, REG_SUS_LEVEL}, sus);
    step(1, {c, REG_SUS_TIME}, tim);
    step(1, {c, REG_REL_STEP}, rel);
    step(1, {c, REG_MODE}, {31'b0, md});
  endtask

  task automatic test_reset();
    logic [31:0] v;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (env0 !== 64'h0 || idle0 !== 4'hF || env1 !== 32'h0 || idle1 !== 2'b11) begin
      n_err++;
      $display("FAIL reset_outputs env0=%h idle0=%b env1=%h idle1=%b required 0/1111/0/11",
               env0, idle0, env1, idle1);
    end
    reset_n = 1'b1;
    model_reset();
    rd0({2'd0, REG_IDLE_VEC}, v);
    n_vec++;
    if (v !== 32'hF) begin
      n_err++; $display("FAIL reset_idle_vec got=%h required=0000000f", v);
    end
  endtask

  task automatic test_timed();
    logic [31:0] v;
    int seen[8];
    seen = '{default: 0};
    prog(0, 32'h0800_0000, 32'h1000_0000, 32'h4000_0000, 32'd10, 32'h1000_0000, 1'b0);
    step(1, {2'd0, REG_CTRL}, 32'h1);
    for (int i = 0; i < 100; i++) begin
      rd0({2'd0, REG_CTRL}, v);
      seen[v[4:2]]++;
      n_vec++;
      if (v !== model_rd({2'd0, REG_CTRL}) || env_of(0) !== model_env(0)) begin
        n_err++;
        $display("FAIL timed_cycle%0d rd=%h env=%h required rd=%h env=%h",
                 i, v, env_of(0), model_rd({2'd0, REG_CTRL}), model_env(0));
      end
      if (i == 15 || i == 16) begin
        n_vec++;
        if (env_of(0) !== ((i == 15) ? 16'hF000 : 16'hFFFF)) begin
          n_err++; $display("FAIL timed_attack_env update%0d got=%h", i, env_of(0));
        end
      end
      if (m_ph[0] == 0) break;
      step(0, 5'd0, 32'd0);
    end
    n_vec++;
    if (seen[1] != 16 || seen[3] != 11 || seen[4] != 4 || idle0[0] !== 1'b1) begin
      n_err++;
      $display("FAIL timed_phase_lengths atk=%0d sus=%0d rel=%0d idle=%b required 16/11/4/1",
               seen[1], seen[3], seen[4], idle0[0]);
    end
  endtask

  task automatic test_gate();
    logic [31:0] v;
    prog(1, 32'h0800_0000, 32'h1000_0000, 32'h4000_0000, 32'd10, 32'h1000_0000, 1'b1);
    step(1, {2'd1, REG_CTRL}, 32'h1);
    for (int i = 0; i < 50 && m_ph[1] != 3; i++) step(0, 5'd0, 32'd0);
    for (int i = 0; i < 1000; i++) begin
      rd0({2'd1, REG_CTRL}, v);
      n_vec++;
      if (env_of(1) !== 16'h8000 || v !== 32'hC || env_of(0) !== 16'h0 || idle0[0] !== 1'b1) begin
        n_err++;
        $display("FAIL gate_hold cycle%0d env1=%h rd=%h env0=%h idle0=%b required 8000/c/0/1",
                 i, env_of(1), v, env_of(0), idle0[0]);
      end
      step(0, 5'd0, 32'd0);
    end
    step(1, {2'd1, REG_CTRL}, 32'h2);
    rd0({2'd1, REG_CTRL}, v);
    n_vec++;
    if (v !== 32'h10) begin
      n_err++; $display("FAIL gate_stop_state rd=%h required=00000010", v);
    end
    for (int i = 0; i < 50 && m_ph[1] != 0; i++) begin
      step(0, 5'd0, 32'd0);
      n_vec++;
      if (env_of(1) !== model_env(1)) begin
        n_err++; $display("FAIL gate_release env1=%h required=%h", env_of(1), model_env(1));
      end
    end
    n_vec++;
    if (idle0[1:0] !== 2'b11 || env_of(1) !== 16'h0) begin
      n_err++; $display("FAIL gate_end idle=%b env1=%h required 11/0", idle0[1:0], env_of(1));
    end
  endtask

  task automatic test_retrigger();
    logic [31:0] v;
    prog(2, 32'h0800_0000, 32'h1000_0000, 32'h4000_0000, 32'd2, 32'h1000_0000, 1'b0);
    step(1, {2'd2, REG_CTRL}, 32'h1);
    for (int i = 0; i < 100 && !(m_ph[2] == 4 && m_lvl[2] == 64'h2000_0000); i++) begin
      step(0, 5'd0, 32'd0);
      n_vec++;
      if (env_of(2) !== model_env(2)) begin
        n_err++; $display("FAIL retrig_pre env2=%h required=%h", env_of(2), model_env(2));
      end
    end
    n_vec++;
    if (!(m_ph[2] == 4 && m_lvl[2] == 64'h2000_0000) || env_of(2) !== 16'h4000) begin
      n_err++; $display("FAIL retrig_reach_release env2=%h required=4000", env_of(2));
    end
    step(1, {2'd2, REG_CTRL}, 32'h1);
    for (int u = 0; u <= 12; u++) begin
      n_vec++;
      if (env_of(2) < 16'h4000 || env_of(2) !== model_env(2)) begin
        n_err++; $display("FAIL retrig_climb update%0d env2=%h required=%h", u, env_of(2), model_env(2));
      end
      if (u < 12) step(0, 5'd0, 32'd0);
    end
    rd0({2'd2, REG_CTRL}, v);
    n_vec++;
    if (env_of(2) !== 16'hFFFF || v !== 32'h8) begin
      n_err++; $display("FAIL retrig_max env2=%h rd=%h required ffff/8", env_of(2), v);
    end
    for (int i = 0; i < 100 && m_ph[2] != 0; i++) step(0, 5'd0, 32'd0);
  endtask

  task automatic test_zero_steps();
    logic [31:0] v, sus;
    longint lvl;
    sus = $urandom;
    lvl = (longint'(sus) > MAXV) ? MAXV : longint'(sus);
    prog(3, 32'h0, 32'h0, sus, 32'($urandom_range(0, 5)), 32'h0, 1'b0);
    step(1, {2'd3, REG_CTRL}, 32'h1);
    step(0, 5'd0, 32'd0);
    rd0({2'd3, REG_CTRL}, v);
    n_vec++;
    if (env_of(3) !== 16'hFFFF || v !== 32'h8) begin
      n_err++; $display("FAIL zero_attack env3=%h rd=%h required ffff/8", env_of(3), v);
    end
    step(0, 5'd0, 32'd0);
    rd0({2'd3, REG_CTRL}, v);
    n_vec++;
    if (env_of(3) !== 16'(lvl >> 15) || v !== 32'hC) begin
      n_err++; $display("FAIL zero_decay env3=%h rd=%h required %h/c", env_of(3), v, 16'(lvl >> 15));
    end
    for (int i = 0; i < 20 && m_ph[3] != 4; i++) step(0, 5'd0, 32'd0);
    step(0, 5'd0, 32'd0);
    n_vec++;
    if (idle0[3] !== 1'b1 || env_of(3) !== 16'h0) begin
      n_err++; $display("FAIL zero_release idle3=%b env3=%h required 1/0", idle0[3], env_of(3));
    end
  endtask

  task automatic test_abort_reset_readback();
    logic [31:0] v;
    step(1, {2'd0, REG_CTRL}, 32'h1);
    for (int i = 0; i < 30 && m_ph[0] != 2; i++) step(0, 5'd0, 32'd0);
    step(0, 5'd0, 32'd0);
    step(1, {2'd0, REG_CTRL}, 32'h7);
    rd0({2'd0, REG_CTRL}, v);
    n_vec++;
    if (idle0[0] !== 1'b1 || env_of(0) !== 16'h0 || v !== 32'h1) begin
      n_err++; $display("FAIL abort_all_bits idle0=%b env0=%h rd=%h required 1/0/1", idle0[0], env_of(0), v);
    end
    step(1, {2'd0, REG_CTRL}, 32'h1);
    repeat (3) step(0, 5'd0, 32'd0);
    #2 reset_n = 1'b0;
    #1;
    n_vec++;
    if (env0 !== 64'h0 || idle0 !== 4'hF || idle1 !== 2'b11) begin
      n_err++; $display("FAIL async_reset env0=%h idle0=%b idle1=%b required 0/1111/11", env0, idle0, idle1);
    end
    reset_n = 1'b1;
    model_reset();
    step(1, {2'd1, REG_CTRL}, 32'h1);
    rd0({2'd0, REG_IDLE_VEC}, v);
    n_vec++;
    if (v !== 32'hD) begin
      n_err++; $display("FAIL idle_vec_read got=%h required=0000000d", v);
    end
    rd0({2'd1, REG_CTRL}, v);
    n_vec++;
    if (v !== 32'h4) begin
      n_err++; $display("FAIL state_read ch1 got=%h required=00000004", v);
    end
    for (int i = 0; i < 10 && m_ph[1] != 0; i++) step(0, 5'd0, 32'd0);
  endtask

  task automatic test_random();
    logic [31:0] v, d;
    logic [4:0]  a, ra;
    bit wr;
    for (int n = 0; n < 2000; n++) begin
      wr = ($urandom_range(0, 9) < 3);
      a  = 5'($urandom_range(0, 31));
      case (a[2:0])
        3'd0:               d = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 7))
                                                            : 32'($urandom_range(1, 2));
        3'd1, 3'd2, 3'd4:   d = ($urandom_range(0, 7) == 0) ? 32'h0
                                                            : $urandom_range(1, 32'h1800_0000);
        3'd3:               d = 32'($urandom_range(0, 12));
        default:            d = $urandom;
      endcase
      step(wr, a, d);
      for (int c = 0; c < 4; c++) begin
        n_vec++;
        if (env_of(c) !== model_env(c) || idle0[c] !== (m_ph[c] == 0)) begin
          n_err++;
          $display("FAIL random cyc%0d ch%0d env=%h idle=%b required env=%h idle=%b",
                   n, c, env_of(c), idle0[c], model_env(c), m_ph[c] == 0);
        end
      end
      ra = 5'($urandom_range(0, 31));
      rd0(ra, v);
      n_vec++;
      if (v !== model_rd(ra)) begin
        n_err++; $display("FAIL random_read cyc%0d addr=%h got=%h required=%h", n, ra, v, model_rd(ra));
      end
    end
  endtask

  task automatic test_bounds();
    logic [31:0] v;
    step1({2'd3, REG_ATK_STEP}, 32'h1000_0000);
    step1({2'd3, REG_CTRL}, 32'h1);
    repeat (4) begin
      @(posedge clk); #1;
      n_vec++;
      if (idle1 !== 2'b11 || env1 !== 32'h0) begin
        n_err++; $display("FAIL bounds_ignored idle1=%b env1=%h required 11/0", idle1, env1);
      end
    end
    rd1({2'd3, REG_CTRL}, v);
    n_vec++;
    if (v !== 32'h0) begin
      n_err++; $display("FAIL bounds_state_read got=%h required=0", v);
    end
    rd1({2'd0, REG_IDLE_VEC}, v);
    n_vec++;
    if (v !== 32'h3) begin
      n_err++; $display("FAIL bounds_idle_vec got=%h required=00000003", v);
    end
    step1({2'd1, REG_CTRL}, 32'h1);
    rd1({2'd1, REG_CTRL}, v);
    n_vec++;
    if (idle1 !== 2'b01 || v !== 32'h4) begin
      n_err++; $display("FAIL bounds_live_ch1 idle1=%b rd=%h required 01/4", idle1, v);
    end
    step1({2'd1, REG_CTRL}, 32'h4);
  endtask

  initial begin
    bus0.cs = 1'b0; bus0.read = 1'b0; bus0.write = 1'b0; bus0.addr = '0; bus0.wr_data = '0;
    bus1.cs = 1'b0; bus1.read = 1'b0; bus1.write = 1'b0; bus1.addr = '0; bus1.wr_data = '0;
    model_reset();
    test_reset();
    test_timed();
    test_gate();
    test_retrigger();
    test_zero_steps();
    test_abort_reset_readback();
    test_random();
    test_bounds();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
